// File: rtl/writeback_queue.sv
// writeback_queue: buffers register-file writes from units that finish out of step
// with the pipeline. Writes drain in arrival order, one per cycle. Two bypass ports
// return the newest pending value of a register.

// One bypass port. Entries arrive ordered oldest (index 0) to newest, and the last
// valid match wins, so duplicate registers resolve to the youngest write.
module wb_lookup #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][4:0]  ord_sel,
  input  logic [DEPTH-1:0][31:0] ord_dat,
  input  logic [DEPTH-1:0]       ord_vld,
  input  logic [4:0]             sel,
  output logic                   hit,
  output logic [31:0]            dat
);
  // Scan from oldest to newest; a later match overrides an earlier one. r0 never hits.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && (sel != 5'd0) && (ord_sel[i] == sel)) begin
        hit = 1'b1;
        dat = ord_dat[i];
      end
    end
  end
endmodule

module writeback_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_wsel,
  input  logic [31:0]   in_wdat,
  input  logic          rf_hold,
  output logic          rf_WEN,
  output logic [4:0]    rf_wsel,
  output logic [31:0]   rf_wdat,
  input  logic [4:0]    lk_sel1,
  input  logic [4:0]    lk_sel2,
  output logic          lk_hit1,
  output logic          lk_hit2,
  output logic [31:0]   lk_dat1,
  output logic [31:0]   lk_dat2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW     = $clog2(DEPTH);
  localparam int NPORTS = 2;

  typedef struct packed {
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } ent_t;

  ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic enq_fire, enq_store, drn_fire;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign in_ready = !full;

  // Handshake completes for r0 too, but only non-zero destinations take a slot.
  assign enq_fire  = in_valid && in_ready;
  assign enq_store = enq_fire && (in_wsel != 5'd0);
  assign drn_fire  = !empty && !rf_hold;

  // Head entry is always presented; WEN alone says whether it is written this cycle.
  always_comb begin
    rf_WEN  = drn_fire;
    rf_wsel = empty ? 5'd0  : mem_q[head_q].wsel;
    rf_wdat = empty ? 32'd0 : mem_q[head_q].wdat;
  end

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(enq_store) - CW'(drn_fire);
    if (enq_store) begin
      mem_d[tail_q] = '{wsel: in_wsel, wdat: in_wdat};
      tail_d        = tail_q + PW'(1);
    end
    if (drn_fire)
      head_d = head_q + PW'(1);
  end

  // State registers; reset drops every pending write.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Rotate storage into age order (0 = head) so lookup ports need no pointer math.
  logic [DEPTH-1:0][4:0]  ord_sel;
  logic [DEPTH-1:0][31:0] ord_dat;
  logic [DEPTH-1:0]       ord_vld;

  // Age-ordered view of valid entries; the entry draining now is still included.
  always_comb begin
    ord_sel = '0;
    ord_dat = '0;
    ord_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_sel[i] = mem_q[head_q + PW'(i)].wsel;
      ord_dat[i] = mem_q[head_q + PW'(i)].wdat;
      ord_vld[i] = (CW'(i) < count_q);
    end
  end

  logic [NPORTS-1:0][4:0]  lk_sel;
  logic [NPORTS-1:0]       lk_hit;
  logic [NPORTS-1:0][31:0] lk_dat;

  assign lk_sel  = {lk_sel2, lk_sel1};
  assign lk_hit1 = lk_hit[0];
  assign lk_hit2 = lk_hit[1];
  assign lk_dat1 = lk_dat[0];
  assign lk_dat2 = lk_dat[1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_lk
    wb_lookup #(.DEPTH(DEPTH)) u_lk (
      .ord_sel (ord_sel),
      .ord_dat (ord_dat),
      .ord_vld (ord_vld),
      .sel     (lk_sel[p]),
      .hit     (lk_hit[p]),
      .dat     (lk_dat[p])
    );
  end
endmodule
